// File: rtl/ccff_chain_loader_if.sv
// Stream and chain-side signals of the configuration-chain loader.
// The slave modport is the loader; the master modport is the bitstream source and chain.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic              start;
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              ccff_head;
    logic              ccff_shift_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic              tail_parity;

    modport slave (
        input  start, s_data, s_valid, ccff_tail,
        output s_ready, ccff_head, ccff_shift_en, busy, done, tail_parity
    );

    modport master (
        output start, s_data, s_valid, ccff_tail,
        input  s_ready, ccff_head, ccff_shift_en, busy, done, tail_parity
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises a word-wide bitstream MSB-first into a p_ccff configuration chain,
// gating the chain clock and accumulating parity of the old contents leaving the tail.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset,
    ccff_chain_loader_if.slave    bus
);
    localparam int WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BC_W  = $clog2(CHAIN_LEN + 1);
    localparam int WC_W  = $clog2(WORDS + 1);
    localparam int BL_W  = $clog2(WORD_W + 1);

    localparam logic [BC_W-1:0] LEN_C   = BC_W'(CHAIN_LEN);
    localparam logic [BC_W-1:0] LAST_C  = BC_W'(CHAIN_LEN - 1);
    localparam logic [WC_W-1:0] WORDS_C = WC_W'(WORDS);
    localparam logic [BL_W-1:0] WORD_C  = BL_W'(WORD_W);
    localparam logic [BL_W-1:0] ONE_C   = BL_W'(1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state, state_nxt;
    logic [WORD_W-1:0] word_buf;
    logic [BL_W-1:0]   bits_left;
    logic [BC_W-1:0]   bit_cnt;
    logic [WC_W-1:0]   word_cnt;
    logic              parity_q;
    logic              shift;
    logic              ready;
    logic              accept;
    logic              last_shift;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shift      = 1'b0;
        ready      = 1'b0;
        last_shift = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = LOAD;
            end
            LOAD: begin
                shift      = (bits_left != '0) && (bit_cnt < LEN_C);
                // Refill on the cycle the final buffered bit leaves, so words stream gap-free.
                ready      = (word_cnt < WORDS_C) &&
                             ((bits_left == '0) || ((bits_left == ONE_C) && shift));
                last_shift = shift && (bit_cnt == LAST_C);
                if (last_shift) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept = ready && bus.s_valid;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            word_buf  <= '0;
            bits_left <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            parity_q  <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                bit_cnt  <= '0;
                word_cnt <= '0;
                parity_q <= 1'b0;
            end
            if (shift) begin
                bit_cnt  <= bit_cnt + 1'b1;
                parity_q <= parity_q ^ bus.ccff_tail;
            end
            // The final shift discards any unused low bits of a partial last word.
            if (last_shift) begin
                word_buf  <= '0;
                bits_left <= '0;
            end else if (accept) begin
                word_buf  <= bus.s_data;
                bits_left <= WORD_C;
                word_cnt  <= word_cnt + 1'b1;
            end else if (shift) begin
                word_buf  <= word_buf << 1;
                bits_left <= bits_left - 1'b1;
            end
        end
    end

    assign bus.s_ready       = ready;
    assign bus.ccff_shift_en = shift;
    assign bus.ccff_head     = word_buf[WORD_W-1];
    assign bus.busy          = (state == LOAD);
    assign bus.done          = (state == DONE);
    assign bus.tail_parity   = parity_q;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 16-stage/8-bit instance and a 3-stage/4-bit instance,
// each driving a behavioural chain, checked against bitstream and parity expectations.
module tb_ccff_chain_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    ccff_chain_loader_if #(.WORD_W(8)) m16 ();
    ccff_chain_loader_if #(.WORD_W(4)) m3 ();

    ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
        .prog_clk(clk), .prog_reset(rst), .bus(m16)
    );
    ccff_chain_loader #(.CHAIN_LEN(3), .WORD_W(4)) dut3 (
        .prog_clk(clk), .prog_reset(rst), .bus(m3)
    );

    // Behavioural p_ccff chains: stage 0 takes head, the last stage drives tail.
    logic [15:0] chain16 = '0;
    logic [2:0]  chain3  = '0;
    assign m16.ccff_tail = chain16[15];
    assign m3.ccff_tail  = chain3[2];
    always @(posedge clk) if (m16.ccff_shift_en) chain16 <= {chain16[14:0], m16.ccff_head};
    always @(posedge clk) if (m3.ccff_shift_en) chain3 <= {chain3[1:0], m3.ccff_head};

    task automatic run16(input logic [15:0] stream, input int stall_len, input bit rand_gaps,
                         input bit glitch, input int abort_after,
                         output int cyc, output int nshift, output int nacc, output int ndone,
                         output int low_run, output int max_run, output logic [15:0] heads);
        logic [7:0] w [2];
        int   wi, stalled, run;
        logic rdy;
        w[0] = stream[15:8];
        w[1] = stream[7:0];
        wi = 0; stalled = 0; run = 0;
        cyc = 0; nshift = 0; nacc = 0; ndone = 0; low_run = 0; max_run = 0; heads = '0;
        @(negedge clk); m16.start = 1'b1;
        @(negedge clk); m16.start = 1'b0;
        while (cyc < 300) begin
            #1;
            rdy = m16.s_ready;
            if (rdy && wi == 1 && stalled < stall_len) begin
                m16.s_valid = 1'b0;
                stalled++;
            end else if (rand_gaps && $urandom_range(0, 3) == 0) begin
                m16.s_valid = 1'b0;
            end else begin
                m16.s_valid = (wi < 2);
            end
            m16.s_data = m16.s_valid ? w[wi[0]] : 8'($urandom);
            if (m16.s_valid && rdy) begin
                nacc++;
                wi++;
            end
            if (m16.ccff_shift_en) begin
                heads = {heads[14:0], m16.ccff_head};
                nshift++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
                if (nshift > 0 && nshift < 16) low_run++;
            end
            if (m16.done) begin
                ndone++;
                break;
            end
            m16.start = (glitch && cyc == 6);
            if (abort_after > 0 && nshift == abort_after) break;
            cyc++;
            @(negedge clk);
        end
        m16.s_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_total++; if ({m16.busy, m16.done, m16.s_ready, m16.ccff_shift_en, m16.ccff_head, m16.tail_parity} !== 6'b0)
            $display("FAIL reset16 outputs=%b want 000000", {m16.busy, m16.done, m16.s_ready, m16.ccff_shift_en, m16.ccff_head, m16.tail_parity});
        else n_pass++;
        n_total++; if ({m3.busy, m3.done, m3.s_ready, m3.ccff_shift_en, m3.ccff_head, m3.tail_parity} !== 6'b0)
            $display("FAIL reset3 outputs=%b want 000000", {m3.busy, m3.done, m3.s_ready, m3.ccff_shift_en, m3.ccff_head, m3.tail_parity});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic(output int base_cyc);
        int cyc, ns, na, nd, lr, mr;
        logic [15:0] h;
        logic exp_par;
        exp_par = ^chain16;
        run16(16'hA53C, 0, 1'b0, 1'b0, 0, cyc, ns, na, nd, lr, mr, h);
        base_cyc = cyc;
        n_total++; if (mr !== 16) $display("FAIL t1_shift_run got=%0d want=16", mr); else n_pass++;
        n_total++; if (h !== 16'hA53C) $display("FAIL t1_heads got=%h want=a53c", h); else n_pass++;
        n_total++; if (cyc !== 17) $display("FAIL t1_latency got=%0d want=17", cyc); else n_pass++;
        n_total++; if (nd !== 1) $display("FAIL t1_done got=%0d want=1", nd); else n_pass++;
        n_total++; if (m16.tail_parity !== exp_par) $display("FAIL t1_parity got=%b want=%b", m16.tail_parity, exp_par); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (chain16 !== 16'hA53C) $display("FAIL t1_chain got=%h want=a53c", chain16); else n_pass++;
        n_total++; if ({m16.done, m16.busy} !== 2'b00) $display("FAIL t1_done_width got=%b want=00", {m16.done, m16.busy}); else n_pass++;
    endtask

    task automatic test_stall(input int base_cyc);
        int cyc, ns, na, nd, lr, mr;
        logic [15:0] h;
        run16(16'hA53C, 5, 1'b0, 1'b0, 0, cyc, ns, na, nd, lr, mr, h);
        n_total++; if (lr !== 5) $display("FAIL t2_stall_cycles got=%0d want=5", lr); else n_pass++;
        n_total++; if (cyc !== base_cyc + 5) $display("FAIL t2_duration got=%0d want=%0d", cyc, base_cyc + 5); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (chain16 !== 16'hA53C) $display("FAIL t2_chain got=%h want=a53c", chain16); else n_pass++;
    endtask

    task automatic test_parity;
        logic [15:0] pre [2];
        logic [15:0] h;
        int cyc, ns, na, nd, lr, mr;
        pre[0] = 16'h0001;
        pre[1] = 16'h0003;
        for (int i = 0; i < 2; i++) begin
            run16(pre[i], 0, 1'b0, 1'b0, 0, cyc, ns, na, nd, lr, mr, h);
            @(negedge clk);
            run16(16'hFFFF, 0, 1'b0, 1'b0, 0, cyc, ns, na, nd, lr, mr, h);
            repeat (2) @(negedge clk);
            #1;
            n_total++; if (m16.tail_parity !== ^pre[i])
                $display("FAIL t4_parity pre=%h got=%b want=%b", pre[i], m16.tail_parity, ^pre[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        int cyc, ns, na, nd, lr, mr, dn;
        logic [15:0] h;
        logic exp_par;
        run16(16'hA53C, 0, 1'b0, 1'b0, 5, cyc, ns, na, nd, lr, mr, h);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        n_total++; if ({m16.busy, m16.done, m16.s_ready, m16.ccff_shift_en, m16.tail_parity} !== 5'b0)
            $display("FAIL t5_reset_outputs got=%b want=00000", {m16.busy, m16.done, m16.s_ready, m16.ccff_shift_en, m16.tail_parity});
        else n_pass++;
        rst = 1'b0;
        dn = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (m16.done) dn++;
        end
        n_total++; if (dn !== 0) $display("FAIL t5_no_done got=%0d want=0", dn); else n_pass++;
        exp_par = ^chain16;
        run16(16'hA53C, 0, 1'b0, 1'b0, 0, cyc, ns, na, nd, lr, mr, h);
        n_total++; if (m16.tail_parity !== exp_par) $display("FAIL t5_rerun_parity got=%b want=%b", m16.tail_parity, exp_par); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (chain16 !== 16'hA53C) $display("FAIL t5_rerun_chain got=%h want=a53c", chain16); else n_pass++;
    endtask

    task automatic test_start_ignored;
        int cyc, ns, na, nd, lr, mr;
        logic [15:0] h;
        run16(16'h5AC3, 0, 1'b0, 1'b1, 0, cyc, ns, na, nd, lr, mr, h);
        m16.start = 1'b1;
        n_total++; if (na !== 2) $display("FAIL t6_words got=%0d want=2", na); else n_pass++;
        n_total++; if (cyc !== 17) $display("FAIL t6_latency got=%0d want=17", cyc); else n_pass++;
        @(negedge clk); m16.start = 1'b0; #1;
        n_total++; if (m16.busy !== 1'b0) $display("FAIL t6_done_start busy=%b want=0", m16.busy); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (m16.busy !== 1'b0) $display("FAIL t6_idle busy=%b want=0", m16.busy); else n_pass++;
        n_total++; if (chain16 !== 16'h5AC3) $display("FAIL t6_chain got=%h want=5ac3", chain16); else n_pass++;
    endtask

    task automatic test_random16;
        int cyc, ns, na, nd, lr, mr;
        logic [15:0] h, stream;
        logic exp_par;
        for (int it = 0; it < 6; it++) begin
            stream = 16'($urandom);
            exp_par = ^chain16;
            run16(stream, $urandom_range(0, 4), 1'b1, 1'b0, 0, cyc, ns, na, nd, lr, mr, h);
            n_total++; if (h !== stream) $display("FAIL rnd_heads got=%h want=%h", h, stream); else n_pass++;
            n_total++; if ({na, ns, nd} !== {32'd2, 32'd16, 32'd1})
                $display("FAIL rnd_counts words=%0d shifts=%0d done=%0d want 2/16/1", na, ns, nd);
            else n_pass++;
            n_total++; if (m16.tail_parity !== exp_par) $display("FAIL rnd_parity got=%b want=%b", m16.tail_parity, exp_par); else n_pass++;
            @(negedge clk); #1;
            n_total++; if (chain16 !== stream) $display("FAIL rnd_chain got=%h want=%h", chain16, stream); else n_pass++;
        end
    endtask

    task automatic test_partial;
        logic [3:0] w;
        logic [2:0] h;
        int na, ns, nd, late_rdy;
        bit seen_acc;
        for (int it = 0; it < 4; it++) begin
            w = (it == 0) ? 4'hB : 4'($urandom);
            na = 0; ns = 0; nd = 0; late_rdy = 0; seen_acc = 0; h = '0;
            @(negedge clk); m3.start = 1'b1;
            @(negedge clk); m3.start = 1'b0;
            m3.s_valid = 1'b1;
            m3.s_data  = w;
            for (int c = 0; c < 10; c++) begin
                #1;
                if (m3.s_ready) begin
                    if (seen_acc) late_rdy++;
                    na++;
                    seen_acc = 1;
                end
                if (m3.ccff_shift_en) begin
                    h = {h[1:0], m3.ccff_head};
                    ns++;
                end
                if (m3.done) nd++;
                @(negedge clk);
            end
            m3.s_valid = 1'b0;
            n_total++; if (na !== 1 || late_rdy !== 0) $display("FAIL t3_words got=%0d late_ready=%0d want=1/0", na, late_rdy); else n_pass++;
            n_total++; if (h !== w[3:1] || ns !== 3) $display("FAIL t3_heads got=%b/%0d want=%b/3", h, ns, w[3:1]); else n_pass++;
            n_total++; if (nd !== 1) $display("FAIL t3_done got=%0d want=1", nd); else n_pass++;
            n_total++; if (chain3 !== w[3:1]) $display("FAIL t3_chain got=%b want=%b", chain3, w[3:1]); else n_pass++;
        end
    endtask

    initial begin
        int base_cyc;
        m16.start = 1'b0; m16.s_valid = 1'b0; m16.s_data = '0;
        m3.start  = 1'b0; m3.s_valid  = 1'b0; m3.s_data  = '0;
        test_reset();
        test_basic(base_cyc);
        test_stall(base_cyc);
        test_partial();
        test_parity();
        test_reset_mid();
        test_start_ignored();
        test_random16();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
